// File: rtl/keymap_setting.sv
// keymap_setting
//
// Key-remapping capture unit for the piano front end. After a start pulse it
// collects N_KEYS debounced key presses, one per note slot starting at slot 0
// (do). A key that already owns a slot is rejected. An escape pulse abandons
// the capture. A full set of presses is committed to the live map in one step.
//
// Optional feature: define KEYMAP_UNDO_EN to add the pose_undo input. It steps
// back one slot during capture.
//
// Ports:
//   slow_clk    - system slow clock (50 Hz)
//   rst_n       - asynchronous active-low reset
//   start       - pulse: begin a capture (ignored while one is in progress)
//   pose_buts   - per-key press pulses, bit k = key k
//   pose_esc    - pulse: abort capture, shadow map discarded
//   pose_undo   - pulse: release the most recently filled slot (KEYMAP_UNDO_EN only)
//   perm_flat   - committed map, slot i at [i*IDX_W +: IDX_W]
//   setting_cnt - slots filled so far in the current capture
//   busy        - high while capturing or committing
//   done        - one-cycle pulse when a new map is committed
//   aborted     - one-cycle pulse when a capture is aborted
//   dup_err     - one-cycle pulse when a press of an already-used key is rejected

module keymap_setting #(
  parameter int N_KEYS = 8,
  parameter int IDX_W  = 3
) (
  input  logic                    slow_clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [N_KEYS-1:0]       pose_buts,
  input  logic                    pose_esc,
`ifdef KEYMAP_UNDO_EN
  input  logic                    pose_undo,
`endif
  output logic [N_KEYS*IDX_W-1:0] perm_flat,
  output logic [IDX_W:0]          setting_cnt,
  output logic                    busy,
  output logic                    done,
  output logic                    aborted,
  output logic                    dup_err
);

  typedef enum logic [1:0] {IDLE, CAPTURE, COMMIT} state_t;

  localparam logic [IDX_W:0] LAST_SLOT = (IDX_W+1)'(N_KEYS - 1);

  state_t            state;
  logic [IDX_W-1:0]  shadow [N_KEYS];
  logic [N_KEYS-1:0] used;

  logic [IDX_W-1:0]  key_idx;
  logic              key_onehot;
  logic              key_is_used;
  logic [IDX_W-1:0]  slot;

  // setting_cnt never exceeds N_KEYS-1, so its low bits address the shadow map.
  assign slot = setting_cnt[IDX_W-1:0];

  // Decode the press vector. Only a single press in a cycle counts as a key.
  // With a one-hot vector, overlapping it with the used mask tells whether
  // that key already owns a slot.
  always_comb begin
    key_idx = '0;
    for (int k = 0; k < N_KEYS; k++) begin
      if (pose_buts[k]) key_idx = IDX_W'(k);
    end
    key_onehot  = (pose_buts != '0) &&
                  ((pose_buts & (pose_buts - N_KEYS'(1))) == '0);
    key_is_used = |(pose_buts & used);
  end

  always_ff @(posedge slow_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      setting_cnt <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      dup_err     <= 1'b0;
      used        <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        shadow[i]                    <= '0;
        perm_flat[i*IDX_W +: IDX_W]  <= IDX_W'(i);
      end
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      dup_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= CAPTURE;
            busy        <= 1'b1;
            used        <= '0;
            setting_cnt <= '0;
          end
        end
        CAPTURE: begin
          if (pose_esc) begin
            state       <= IDLE;
            busy        <= 1'b0;
            aborted     <= 1'b1;
            setting_cnt <= '0;
          end
`ifdef KEYMAP_UNDO_EN
          // Undo takes precedence over any press in the same cycle.
          else if (pose_undo) begin
            if (setting_cnt != '0) begin
              setting_cnt                  <= setting_cnt - (IDX_W+1)'(1);
              used[shadow[slot - IDX_W'(1)]] <= 1'b0;
            end
          end
`endif
          else if (key_onehot) begin
            if (key_is_used) begin
              dup_err <= 1'b1;
            end else begin
              shadow[slot] <= key_idx;
              used         <= used | pose_buts;
              // The count holds on the final slot, so it stays at N_KEYS-1.
              if (setting_cnt < LAST_SLOT) setting_cnt <= setting_cnt + (IDX_W+1)'(1);
              else                         state       <= COMMIT;
            end
          end
        end
        COMMIT: begin
          // All inputs are ignored here, so the map is never partly updated.
          for (int i = 0; i < N_KEYS; i++) begin
            perm_flat[i*IDX_W +: IDX_W] <= shadow[i];
          end
          done        <= 1'b1;
          busy        <= 1'b0;
          setting_cnt <= '0;
          state       <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keymap_setting.sv
// tb_keymap_setting
//
// Directed bench for keymap_setting with N_KEYS=8, IDX_W=3.
// Inputs change 1 time unit after each rising edge.
// Outputs are sampled there too, well away from the next edge.

module tb_keymap_setting;

  // Committed maps, written as concatenations from slot 7 down to slot 0.
  localparam logic [23:0] PERM_ID  = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
  localparam logic [23:0] PERM_REV = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
  localparam logic [23:0] PERM_T2  = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd1, 3'd0, 3'd2};
  localparam logic [23:0] PERM_T5  = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd0, 3'd1};

  logic        slow_clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  pose_buts;
  logic        pose_esc;
`ifdef KEYMAP_UNDO_EN
  logic        pose_undo;
`endif
  logic [23:0] perm_flat;
  logic [3:0]  setting_cnt;
  logic        busy;
  logic        done;
  logic        aborted;
  logic        dup_err;

  int vectors    = 0;
  int miscompares = 0;

  keymap_setting #(.N_KEYS(8), .IDX_W(3)) dut (
    .slow_clk    (slow_clk),
    .rst_n       (rst_n),
    .start       (start),
    .pose_buts   (pose_buts),
    .pose_esc    (pose_esc),
`ifdef KEYMAP_UNDO_EN
    .pose_undo   (pose_undo),
`endif
    .perm_flat   (perm_flat),
    .setting_cnt (setting_cnt),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted),
    .dup_err     (dup_err)
  );

  always #5 slow_clk = ~slow_clk;

  // Hold the given inputs for exactly one rising edge, then clear them.
  task automatic applyStimulus(input logic s, input logic [7:0] b, input logic e);
    start     = s;
    pose_buts = b;
    pose_esc  = e;
    @(posedge slow_clk);
    #1;
    start     = 1'b0;
    pose_buts = '0;
    pose_esc  = 1'b0;
  endtask

`ifdef KEYMAP_UNDO_EN
  task automatic applyUndo(input logic [7:0] b);
    pose_undo = 1'b1;
    pose_buts = b;
    @(posedge slow_clk);
    #1;
    pose_undo = 1'b0;
    pose_buts = '0;
  endtask
`endif

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // {busy, done, aborted, dup_err} packed for compact checks.
  function automatic logic [31:0] flags();
    return {28'd0, busy, done, aborted, dup_err};
  endfunction

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    pose_buts = '0;
    pose_esc  = 1'b0;
`ifdef KEYMAP_UNDO_EN
    pose_undo = 1'b0;
`endif
    repeat (2) @(posedge slow_clk);
    #1;
    checkOutput("reset_perm", 32'(perm_flat), 32'(PERM_ID));
    checkOutput("reset_cnt", 32'(setting_cnt), 32'd0);
    checkOutput("reset_flags", flags(), 32'b0000);
    @(negedge slow_clk);
    rst_n = 1'b1;
    @(posedge slow_clk);
    #1;

    $display("[TB] test 1: reversed map");
    applyStimulus(1'b1, 8'h00, 1'b0);
    checkOutput("t1_start_flags", flags(), 32'b1000);
    checkOutput("t1_start_cnt", 32'(setting_cnt), 32'd0);
    for (int j = 0; j < 8; j++) begin
      applyStimulus(1'b0, 8'h80 >> j, 1'b0);
      checkOutput("t1_cnt", 32'(setting_cnt), (j < 7) ? 32'(j + 1) : 32'd7);
      checkOutput("t1_flags", flags(), 32'b1000);
      checkOutput("t1_perm_hold", 32'(perm_flat), 32'(PERM_ID));
    end
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("t1_done_flags", flags(), 32'b0100);
    checkOutput("t1_perm", 32'(perm_flat), 32'(PERM_REV));
    checkOutput("t1_cnt_clr", 32'(setting_cnt), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("t1_done_once", flags(), 32'b0000);

    $display("[TB] test 2: duplicate rejection, esc during commit");
    applyStimulus(1'b1, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h04, 1'b0);
    checkOutput("t2_cnt1", 32'(setting_cnt), 32'd1);
    applyStimulus(1'b0, 8'h04, 1'b0);
    checkOutput("t2_dup_flags", flags(), 32'b1001);
    checkOutput("t2_dup_cnt", 32'(setting_cnt), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("t2_dup_pulse", flags(), 32'b1000);
    applyStimulus(1'b0, 8'h01, 1'b0);
    applyStimulus(1'b0, 8'h02, 1'b0);
    for (int k = 3; k < 8; k++) applyStimulus(1'b0, 8'h01 << k, 1'b0);
    checkOutput("t2_commit_cnt", 32'(setting_cnt), 32'd7);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("t2_done_flags", flags(), 32'b0100);
    checkOutput("t2_perm", 32'(perm_flat), 32'(PERM_T2));

    $display("[TB] test 3: abort");
    applyStimulus(1'b1, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h08, 1'b0);
    applyStimulus(1'b0, 8'h10, 1'b0);
    checkOutput("t3_cnt2", 32'(setting_cnt), 32'd2);
    applyStimulus(1'b0, 8'h20, 1'b1);
    checkOutput("t3_abort_flags", flags(), 32'b0010);
    checkOutput("t3_abort_cnt", 32'(setting_cnt), 32'd0);
    checkOutput("t3_perm", 32'(perm_flat), 32'(PERM_T2));
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("t3_abort_pulse", flags(), 32'b0000);

    $display("[TB] test 4: ignored inputs");
    applyStimulus(1'b0, 8'h01, 1'b1);
    checkOutput("t4_idle_flags", flags(), 32'b0000);
    checkOutput("t4_idle_cnt", 32'(setting_cnt), 32'd0);
    applyStimulus(1'b1, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h03, 1'b0);
    checkOutput("t4_multi_cnt", 32'(setting_cnt), 32'd0);
    checkOutput("t4_multi_flags", flags(), 32'b1000);
    applyStimulus(1'b0, 8'h02, 1'b0);
    applyStimulus(1'b1, 8'h00, 1'b0);
    checkOutput("t4_restart_cnt", 32'(setting_cnt), 32'd1);
    checkOutput("t4_restart_flags", flags(), 32'b1000);
    applyStimulus(1'b0, 8'h00, 1'b1);

    $display("[TB] test 5: reset mid-capture");
    applyStimulus(1'b1, 8'h00, 1'b0);
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 8'h01 << k, 1'b0);
    checkOutput("t5_cnt4", 32'(setting_cnt), 32'd4);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_perm", 32'(perm_flat), 32'(PERM_ID));
    checkOutput("t5_rst_cnt", 32'(setting_cnt), 32'd0);
    checkOutput("t5_rst_flags", flags(), 32'b0000);
    @(negedge slow_clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 8'h02, 1'b0);
    checkOutput("t5_idle_after_rst", flags(), 32'b0000);
    applyStimulus(1'b1, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h02, 1'b0);
    applyStimulus(1'b0, 8'h01, 1'b0);
    for (int k = 2; k < 8; k++) applyStimulus(1'b0, 8'h01 << k, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("t5_done_flags", flags(), 32'b0100);
    checkOutput("t5_perm", 32'(perm_flat), 32'(PERM_T5));

`ifdef KEYMAP_UNDO_EN
    $display("[TB] test 6: undo");
    applyStimulus(1'b1, 8'h00, 1'b0);
    applyUndo(8'h00);
    checkOutput("t6_undo_zero_cnt", 32'(setting_cnt), 32'd0);
    applyStimulus(1'b0, 8'h02, 1'b0);
    applyStimulus(1'b0, 8'h04, 1'b0);
    applyUndo(8'h08);
    checkOutput("t6_undo_cnt", 32'(setting_cnt), 32'd1);
    applyStimulus(1'b0, 8'h04, 1'b0);
    checkOutput("t6_repress_flags", flags(), 32'b1000);
    checkOutput("t6_repress_cnt", 32'(setting_cnt), 32'd2);
    applyStimulus(1'b0, 8'h00, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
